// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between an RV32I core and a word-addressed
// data memory. Turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into
// whole-word accesses. Sub-word stores use a read-modify-write. Misaligned
// accesses and illegal funct3 values complete with err=1 and write nothing.
module mem_access_unit #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          is_store,
    input  logic [2:0]    funct3,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Request fields latched on acceptance; only the word and lane bits of
    // the address matter because memory aliases above them.
    logic          store_q;
    logic [2:0]    funct3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   buf_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          access_err;
    logic          sub_store;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [31:0]   merged;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    assign mem_addr  = addr_q[AW+1:2];
    assign ready     = (state == IDLE);
    assign rdata     = rdata_q;
    assign sub_store = store_q && (funct3_q != 3'b010);

    // Flag misaligned accesses and funct3 values that are not legal for the direction.
    always_comb begin
        access_err = 1'b0;
        if (store_q) begin
            case (funct3_q)
                3'b000:  access_err = 1'b0;
                3'b001:  access_err = addr_q[0];
                3'b010:  access_err = |addr_q[1:0];
                default: access_err = 1'b1;
            endcase
        end else begin
            case (funct3_q)
                3'b000, 3'b100: access_err = 1'b0;
                3'b001, 3'b101: access_err = addr_q[0];
                3'b010:         access_err = |addr_q[1:0];
                default:        access_err = 1'b1;
            endcase
        end
    end

    // Pick the addressed byte/half out of the memory word and extend it.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // Overlay the store byte/half onto the word captured during ACCESS.
    always_comb begin
        merged = buf_q;
        if (funct3_q == 3'b001) begin
            if (addr_q[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end else begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = buf_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory/handshake strobes; a cycle under reset drives nothing.
    always_comb begin
        state_next = state;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 32'd0;
        done       = 1'b0;
        err        = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state_next = ACCESS;
                    end
                end
                ACCESS: begin
                    mem_re = 1'b1;
                    if (access_err || !store_q) begin
                        state_next = RESP;
                    end else if (!sub_store) begin
                        mem_we     = 1'b1;
                        mem_wdata  = wdata_q;
                        state_next = RESP;
                    end else begin
                        state_next = MERGE;
                    end
                end
                MERGE: begin
                    mem_we     = 1'b1;
                    mem_wdata  = merged;
                    state_next = RESP;
                end
                RESP: begin
                    done       = 1'b1;
                    err        = err_q;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Request latching, load result and read-modify-write buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            buf_q    <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        store_q  <= is_store;
                        funct3_q <= funct3;
                        addr_q   <= addr[AW+1:0];
                        wdata_q  <= wdata;
                        rdata_q  <= 32'd0;
                        err_q    <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (access_err) begin
                        err_q <= 1'b1;
                    end else if (!store_q) begin
                        rdata_q <= load_val;
                    end else if (sub_store) begin
                        buf_q <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit. Directed table
// of accesses with hand-computed results, a reset-during-MERGE sequence, and
// random accesses checked against a byte-level behavioural model of memory.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] dmem   [0:255];
    logic [31:0] refMem [0:255];

    int total = 0;
    int bad   = 0;

    // Observations of the most recent transaction.
    logic        obsReadyAtReq;
    logic        obsReadyEarly;
    logic        obsReCyc1;
    int          obsLat;
    int          obsWrites;
    int          obsWrCyc;
    logic [7:0]  obsWrAddr;
    logic [31:0] obsWrData;
    logic [31:0] obsRdata;
    logic        obsErr;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        bit          poke;
        logic        eErr;
        logic [31:0] eRd;
        int          eLat;
        int          eWe;
        logic [7:0]  eWrAddr;
        logic [31:0] eWrData;
    } vec_t;

    vec_t vecs [21];

    mem_access_unit #(.AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, synchronous write.
    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr] <= mem_wdata;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Issue one request and watch the DUT until done or a cycle budget runs out.
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input bit poke);
        int cyc;
        @(negedge clk);
        is_store = st; funct3 = f3; addr = a; wdata = wd; req = 1'b1;
        obsReadyAtReq = ready;
        obsReadyEarly = 1'b0;
        obsReCyc1 = 1'b0;
        obsLat = 0; obsWrites = 0; obsWrCyc = 0; obsWrAddr = 8'd0; obsWrData = 32'd0;
        obsRdata = 32'd0; obsErr = 1'b0;
        cyc = 0;
        while (obsLat == 0 && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) obsReCyc1 = mem_re;
            if (mem_we) begin
                obsWrites++;
                obsWrCyc  = cyc;
                obsWrAddr = mem_addr;
                obsWrData = mem_wdata;
            end
            if (done) begin
                obsLat   = cyc;
                obsRdata = rdata;
                obsErr   = err;
                req      = 1'b0;
            end else begin
                if (ready) obsReadyEarly = 1'b1;
                req      = poke;
                is_store = 1'($urandom_range(0, 1));
                funct3   = 3'($urandom_range(0, 7));
                addr     = $urandom;
                wdata    = $urandom;
            end
        end
        req = 1'b0;
    endtask

    // Behavioural model: byte-lane arithmetic on a word array.
    task automatic modelOp(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic eErr, output logic [31:0] eRd,
                           output int eLat, output int eWe, output logic [7:0] eWrAddr,
                           output logic [31:0] eWrData);
        int size;
        int idx;
        int sh;
        bit illegal;
        logic [31:0] word;
        logic [31:0] val;
        logic [31:0] mask;
        idx = int'((a / 4) % 256);
        sh  = 8 * int'(a % 4);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        illegal = (size == 0) || (st && f3 > 3'd2);
        if (!illegal) illegal = (int'(a % 4) % size) != 0;
        eErr = 1'b0; eRd = 32'd0; eLat = 2; eWe = 0; eWrAddr = 8'(idx); eWrData = 32'd0;
        word = refMem[idx];
        if (illegal) begin
            eErr = 1'b1;
        end else if (!st) begin
            val = word >> sh;
            if (size == 1) begin
                val = val % 256;
                if (f3 == 3'd0 && val >= 128) val = val - 32'd256;
            end else if (size == 2) begin
                val = val % 65536;
                if (f3 == 3'd1 && val >= 32768) val = val - 32'd65536;
            end
            eRd = val;
        end else begin
            if (size == 4) mask = 32'hFFFF_FFFF;
            else mask = ((32'd1 << (8 * size)) - 32'd1) << sh;
            word = (word & ~mask) | ((wd << sh) & mask);
            refMem[idx] = word;
            eWe = 1;
            eWrData = word;
            eLat = (size == 4) ? 2 : 3;
        end
    endtask

    task automatic checkOp(input string tag, input logic st, input logic eErr, input logic [31:0] eRd,
                           input int eLat, input int eWe, input logic [7:0] eWrAddr,
                           input logic [31:0] eWrData);
        checkOutput({tag, ".readyAtReq"}, 32'(obsReadyAtReq), 32'd1);
        checkOutput({tag, ".latency"}, 32'(obsLat), 32'(eLat));
        checkOutput({tag, ".readyLow"}, 32'(obsReadyEarly), 32'd0);
        checkOutput({tag, ".memRe"}, 32'(obsReCyc1), 32'd1);
        checkOutput({tag, ".err"}, 32'(obsErr), 32'(eErr));
        if (!st || eErr) checkOutput({tag, ".rdata"}, obsRdata, eRd);
        checkOutput({tag, ".writes"}, 32'(obsWrites), 32'(eWe));
        if (eWe == 1 && obsWrites == 1) begin
            checkOutput({tag, ".wrAddr"}, 32'(obsWrAddr), 32'(eWrAddr));
            checkOutput({tag, ".wrData"}, obsWrData, eWrData);
            checkOutput({tag, ".wrCycle"}, 32'(obsWrCyc), (eLat == 3) ? 32'd2 : 32'd1);
        end
    endtask

    // Random request checked against the model.
    task automatic randomOp(input int n);
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] tmp;
        logic        eErr;
        logic [31:0] eRd;
        int          eLat;
        int          eWe;
        logic [7:0]  eWrAddr;
        logic [31:0] eWrData;
        st  = 1'($urandom_range(0, 1));
        f3  = 3'($urandom_range(0, 7));
        tmp = $urandom;
        a   = (tmp & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
        wd  = $urandom;
        modelOp(st, f3, a, wd, eErr, eRd, eLat, eWe, eWrAddr, eWrData);
        applyStimulus(st, f3, a, wd, bit'($urandom_range(0, 1)));
        checkOp($sformatf("rand%0d", n), st, eErr, eRd, eLat, eWe, eWrAddr, eWrData);
    endtask

    initial begin
        logic        eErr;
        logic [31:0] eRd;
        int          eLat;
        int          eWe;
        logic [7:0]  eWrAddr;
        logic [31:0] eWrData;

        for (int i = 0; i < 256; i++) begin
            dmem[i]   = 32'd0;
            refMem[i] = 32'd0;
        end

        //            st    f3      addr          wdata         poke eErr  eRd           lat we  wrAddr wrData
        vecs[0]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 0, 1'b0, 32'h0,        2, 1, 8'd4,  32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b010, 32'h10,       32'h0,        0, 1'b0, 32'hDEADBEEF, 2, 0, 8'd0,  32'h0};
        vecs[2]  = '{1'b1, 3'b010, 32'h10,       32'h11223344, 0, 1'b0, 32'h0,        2, 1, 8'd4,  32'h11223344};
        vecs[3]  = '{1'b1, 3'b000, 32'h13,       32'h000000A5, 0, 1'b0, 32'h0,        3, 1, 8'd4,  32'hA5223344};
        vecs[4]  = '{1'b0, 3'b000, 32'h13,       32'h0,        0, 1'b0, 32'hFFFFFFA5, 2, 0, 8'd0,  32'h0};
        vecs[5]  = '{1'b0, 3'b100, 32'h13,       32'h0,        0, 1'b0, 32'h000000A5, 2, 0, 8'd0,  32'h0};
        vecs[6]  = '{1'b1, 3'b001, 32'h12,       32'h00008001, 0, 1'b0, 32'h0,        3, 1, 8'd4,  32'h80013344};
        vecs[7]  = '{1'b0, 3'b001, 32'h12,       32'h0,        0, 1'b0, 32'hFFFF8001, 2, 0, 8'd0,  32'h0};
        vecs[8]  = '{1'b0, 3'b101, 32'h10,       32'h0,        0, 1'b0, 32'h00003344, 2, 0, 8'd0,  32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'h11,       32'h0,        0, 1'b1, 32'h0,        2, 0, 8'd0,  32'h0};
        vecs[10] = '{1'b1, 3'b001, 32'h13,       32'h00001234, 0, 1'b1, 32'h0,        2, 0, 8'd0,  32'h0};
        vecs[11] = '{1'b1, 3'b100, 32'h10,       32'h00000077, 0, 1'b1, 32'h0,        2, 0, 8'd0,  32'h0};
        vecs[12] = '{1'b0, 3'b000, 32'h10,       32'h0,        1, 1'b0, 32'h00000044, 2, 0, 8'd0,  32'h0};
        vecs[13] = '{1'b0, 3'b011, 32'h10,       32'h0,        0, 1'b1, 32'h0,        2, 0, 8'd0,  32'h0};
        vecs[14] = '{1'b0, 3'b010, 32'hABCD0410, 32'h0,        0, 1'b0, 32'h80013344, 2, 0, 8'd0,  32'h0};
        vecs[15] = '{1'b0, 3'b001, 32'h11,       32'h0,        0, 1'b1, 32'h0,        2, 0, 8'd0,  32'h0};
        vecs[16] = '{1'b0, 3'b000, 32'h11,       32'h0,        0, 1'b0, 32'h00000033, 2, 0, 8'd0,  32'h0};
        vecs[17] = '{1'b0, 3'b101, 32'h12,       32'h0,        0, 1'b0, 32'h00008001, 2, 0, 8'd0,  32'h0};
        vecs[18] = '{1'b1, 3'b000, 32'h30,       32'hFFFFFF80, 0, 1'b0, 32'h0,        3, 1, 8'd12, 32'h00000080};
        vecs[19] = '{1'b0, 3'b000, 32'h30,       32'h0,        1, 1'b0, 32'hFFFFFF80, 2, 0, 8'd0,  32'h0};
        vecs[20] = '{1'b1, 3'b010, 32'h12,       32'h55555555, 0, 1'b1, 32'h0,        2, 0, 8'd0,  32'h0};

        // Reset held two cycles while a store is requested.
        rst = 1'b1; req = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0; wdata = 32'hCAFEF00D;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset%0d.ready", i), 32'(ready), 32'd1);
            checkOutput($sformatf("reset%0d.done", i), 32'(done), 32'd0);
            checkOutput($sformatf("reset%0d.memWe", i), 32'(mem_we), 32'd0);
            checkOutput($sformatf("reset%0d.memRe", i), 32'(mem_re), 32'd0);
            checkOutput($sformatf("reset%0d.rdata", i), rdata, 32'd0);
            checkOutput($sformatf("reset%0d.err", i), 32'(err), 32'd0);
            checkOutput($sformatf("reset%0d.memAddr", i), 32'(mem_addr), 32'd0);
            checkOutput($sformatf("reset%0d.memWdata", i), mem_wdata, 32'd0);
        end
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        checkOutput("postReset.ready", 32'(ready), 32'd1);
        checkOutput("postReset.done", 32'(done), 32'd0);
        checkOutput("postReset.noWrite", dmem[0], 32'd0);

        // Directed table.
        for (int i = 0; i < 21; i++) begin
            modelOp(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, eErr, eRd, eLat, eWe, eWrAddr, eWrData);
            applyStimulus(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].poke);
            checkOp($sformatf("vec%0d", i), vecs[i].st, vecs[i].eErr, vecs[i].eRd, vecs[i].eLat,
                    vecs[i].eWe, vecs[i].eWrAddr, vecs[i].eWrData);
        end

        // Reset during the MERGE write of SB 0x10 / 0xFF on 0x11223344.
        modelOp(1'b1, 3'b010, 32'h10, 32'h11223344, eErr, eRd, eLat, eWe, eWrAddr, eWrData);
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h11223344, 0);
        checkOp("rstSetup", 1'b1, eErr, eRd, eLat, eWe, eWrAddr, eWrData);
        @(negedge clk);
        is_store = 1'b1; funct3 = 3'b000; addr = 32'h10; wdata = 32'h000000FF; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checkOutput("rstSeq.accessRe", 32'(mem_re), 32'd1);
        @(negedge clk);
        checkOutput("rstSeq.mergePending", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstSeq.mergeWeGated", 32'(mem_we), 32'd0);
        checkOutput("rstSeq.noDone", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstSeq.readyAfter", 32'(ready), 32'd1);
        checkOutput("rstSeq.doneAfter", 32'(done), 32'd0);
        checkOutput("rstSeq.wordKept", dmem[4], 32'h11223344);
        @(negedge clk);
        checkOutput("rstSeq.stillNoDone", 32'(done), 32'd0);
        checkOutput("rstSeq.stillReady", 32'(ready), 32'd1);
        modelOp(1'b0, 3'b010, 32'h10, 32'h0, eErr, eRd, eLat, eWe, eWrAddr, eWrData);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0);
        checkOp("rstSeq.reload", 1'b0, eErr, eRd, eLat, eWe, eWrAddr, eWrData);

        // Random accesses against the model.
        for (int n = 0; n < 80; n++) begin
            randomOp(n);
        end

        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            checkOutput($sformatf("memImage[%0d]", i), dmem[i], refMem[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit sitting directly upstream of the word-addressed data memory (256 × 32-bit, combinational read, synchronous write, no byte enables). It converts CPU byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses:
- lane selection and sign/zero extension on loads
- read-modify-write for sub-word stores
- misalignment detection
- a req/ready/done handshake to the core

## Interface
Parameters:
- AW, 8, memory word-address width (memory depth 2^AW words)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  access request, sampled only when ready=1
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr  in  32  byte address
- wdata  in  32  store data, low bytes used for SB/SH
- ready  out  1  unit idle, will accept req this cycle
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned or illegal funct3
- rdata  out  32  load result, valid with done
- mem_addr  out  AW  word address to memory
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  32  full word to memory
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- FSM states:
  - IDLE: ready=1. On req=1, latch is_store, funct3, addr, wdata, then go to ACCESS.
  - ACCESS:
    - mem_addr = addr_q[AW+1:2], mem_re=1.
    - On error: go to RESP with err_q=1; no write is issued.
    - Load: extract lane from mem_rdata into rdata_q, go to RESP.
    - SW: mem_we=1, mem_wdata=wdata_q, go to RESP.
    - SB/SH: capture mem_rdata into buf_q, go to MERGE.
  - MERGE: mem_we=1, mem_wdata = buf_q with the target lane replaced, go to RESP.
  - RESP: done=1, err and rdata driven from registers, go to IDLE.
- Address bits above AW+1 are ignored, so memory aliases every 2^(AW+2) bytes.
- Error conditions:
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
  - load funct3 ∈ {011,110,111}
  - store funct3 ∉ {000,001,010}
  - On error: rdata=0 and no memory write.
- Load extraction:
  - byte lane = addr[1:0], half lane = addr[1]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store merge:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces half lane addr[1] with wdata[15:0].
  - Other bytes come from buf_q.
- Request inputs may change freely after acceptance. req while ready=0 is ignored and not queued.
- mem_we is gated by !rst, so no write is issued in a cycle where rst=1.

## Timing
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Cycle numbering: acceptance edge ends cycle 0.
  - Load / SW / error: ACCESS in cycle 1, done in cycle 2 (latency 2).
  - SB/SH: ACCESS in cycle 1, MERGE write in cycle 2, done in cycle 3 (latency 3).
- SW write commits at the end of cycle 1; SB/SH write commits at the end of cycle 2.
- ready is low from cycle 1 through the RESP cycle. The next request can be accepted in the cycle after done, so peak throughput is 1 access per 3 cycles for loads.
- mem_re/mem_we are asserted only in ACCESS/MERGE. mem_addr holds its last value in IDLE and RESP.
- rst at any state: next state IDLE, all outputs return to reset values, the in-flight access is abandoned, and no done is emitted. A MERGE cut by rst writes nothing.

## Test plan
- Reset: hold rst 2 cycles with req=1 → ready=1, done=0, mem_we=0, rdata=0; no request is accepted during rst.
- SW 0x10 / 0xDEADBEEF → mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF in cycle 1, done in cycle 2. Then LW 0x10 → rdata=0xDEADBEEF, err=0, done in cycle 2.
- Word 4 = 0x11223344:
  - SB 0x13 / 0x000000A5 → single MERGE write of 0xA5223344 in cycle 2, done in cycle 3.
  - LB 0x13 → 0xFFFFFFA5.
  - LBU 0x13 → 0x000000A5.
- SH 0x12 / 0x00008001 on 0xA5223344 → write 0x80013344. LH 0x12 → 0xFFFF8001. LHU 0x10 → 0x00003344.
- Errors:
  - LW 0x11 → done with err=1, rdata=0.
  - SH 0x13 → err=1, mem_we never asserted.
  - Store with funct3=100 → err=1.
  - req pulsed during ACCESS → ignored.
- Reset mid-operation: rst=1 during MERGE of SB 0x10/0xFF on 0x11223344 → no mem_we, word unchanged, no done, ready=1 next cycle. A following LW returns 0x11223344.
